// File: rtl/hazard_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_pkg
// Shared definitions for the hazard controller of the 5-stage MIPS pipeline:
// controller state encoding and the NOP instruction word that the IF/ID flush
// path loads in place of the squashed instruction.
// -----------------------------------------------------------------------------
package hazard_ctrl_unit_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // sll $0,$0,0 -- the canonical MIPS NOP, loaded into IF/ID on flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_reg_match.sv
// -----------------------------------------------------------------------------
// hazard_reg_match
// Combinational source/destination register comparator.
// Ports:
//   src_rs_i  - rs index of the instruction in ID
//   src_rt_i  - rt index of the instruction in ID
//   uses_rt_i - ID instruction actually reads rt
//   dst_i     - destination index of the older instruction
//   match_o   - 1 when the ID instruction depends on dst_i
// -----------------------------------------------------------------------------
module hazard_reg_match
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] src_rs_i,
  input  logic [NB_REG-1:0] src_rt_i,
  input  logic              uses_rt_i,
  input  logic [NB_REG-1:0] dst_i,
  output logic              match_o
);

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  assign match_o = (dst_i != '0) &&
                   ((src_rs_i == dst_i) || (uses_rt_i && (src_rt_i == dst_i)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard controller beside the decode stage. Detects load-use and
// branch-in-ID operand hazards, flushes IF/ID on taken branches, drains and
// freezes the pipeline on HALT, and counts hazard stall cycles (saturating).
// Ports:
//   clock_i, reset_i            - clock, asynchronous active-high reset
//   id_*                        - operand/control info of the ID instruction
//   ex_*, mem_*                 - destination info of the EX / MEM instructions
//   resume_i                    - debug restart request (honoured in HALTED)
//   pc_write_o, if_id_write_o   - PC and IF/ID load enables
//   if_id_flush_o               - replace IF/ID with NOP
//   stall_o                     - insert bubble into ID/EX
//   halted_o                    - pipeline drained and frozen
//   stall_count_o               - hazard stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NB_REG       = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_CNT       = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_is_branch_i,
  input  logic              id_branch_taken_i,
  input  logic              id_halt_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [NB_REG-1:0] ex_write_reg_i,
  input  logic              mem_mem_read_i,
  input  logic [NB_REG-1:0] mem_write_reg_i,
  input  logic              resume_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              stall_o,
  output logic              halted_o,
  output logic [NB_CNT-1:0] stall_count_o
);

  localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRN-1:0] DRAIN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  logic ex_match;
  logic mem_match;
  logic lu, bex, bmem, haz;

  logic [1:0]        state_q, state_d;
  logic [NB_DRN-1:0] drain_cnt_q, drain_cnt_d;
  logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;

  hazard_reg_match #(.NB_REG(NB_REG)) u_ex_match (
    .src_rs_i  (id_rs_i),
    .src_rt_i  (id_rt_i),
    .uses_rt_i (id_uses_rt_i),
    .dst_i     (ex_write_reg_i),
    .match_o   (ex_match)
  );

  hazard_reg_match #(.NB_REG(NB_REG)) u_mem_match (
    .src_rs_i  (id_rs_i),
    .src_rt_i  (id_rt_i),
    .uses_rt_i (id_uses_rt_i),
    .dst_i     (mem_write_reg_i),
    .match_o   (mem_match)
  );

  // Branches resolve in ID, so they also wait on an ALU result still in EX
  // and on a load result still in MEM.
  assign lu   = ex_mem_read_i & ex_match;
  assign bex  = id_is_branch_i & ex_reg_write_i & ex_match;
  assign bmem = id_is_branch_i & mem_mem_read_i & mem_match;
  assign haz  = lu | bex | bmem;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (haz) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (id_halt_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - NB_DRN'(1);
        end
      end
      ST_HALTED: begin
        if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    stall_o       = 1'b0;
    halted_o      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (haz) begin
          // ID operands are stale: branch/halt decisions wait for the retry.
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          stall_o       = 1'b1;
        end else if (id_halt_i) begin
          // HALT moves on to EX; the fetched instruction behind it is killed.
          pc_write_o    = 1'b0;
          if_id_flush_o = 1'b1;
        end else if (id_branch_taken_i) begin
          if_id_flush_o = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        stall_o       = 1'b1;
      end
      ST_HALTED: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        stall_o       = 1'b1;
        halted_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  localparam int DRN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_reg, mem_reg;
  logic       urt, br, tk, hlt, ex_rd, ex_wr, mem_rd, res;

  logic        pc_w_a, ifw_a, fl_a, st_a, hd_a;
  logic [15:0] cnt_a;
  logic        pc_w_b, ifw_b, fl_b, st_b, hd_b;
  logic [1:0]  cnt_b;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Bench model state
  bit m_drain, m_halted;
  int m_drain_left, m_cnt;

  hazard_ctrl_unit #(.NB_REG(5), .DRAIN_CYCLES(DRN), .NB_CNT(16)) dut_a (
    .clock_i(clk), .reset_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(urt), .id_is_branch_i(br), .id_branch_taken_i(tk),
    .id_halt_i(hlt), .ex_mem_read_i(ex_rd), .ex_reg_write_i(ex_wr),
    .ex_write_reg_i(ex_reg), .mem_mem_read_i(mem_rd), .mem_write_reg_i(mem_reg),
    .resume_i(res), .pc_write_o(pc_w_a), .if_id_write_o(ifw_a),
    .if_id_flush_o(fl_a), .stall_o(st_a), .halted_o(hd_a), .stall_count_o(cnt_a)
  );

  hazard_ctrl_unit #(.NB_REG(5), .DRAIN_CYCLES(DRN), .NB_CNT(2)) dut_b (
    .clock_i(clk), .reset_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(urt), .id_is_branch_i(br), .id_branch_taken_i(tk),
    .id_halt_i(hlt), .ex_mem_read_i(ex_rd), .ex_reg_write_i(ex_wr),
    .ex_write_reg_i(ex_reg), .mem_mem_read_i(mem_rd), .mem_write_reg_i(mem_reg),
    .resume_i(res), .pc_write_o(pc_w_b), .if_id_write_o(ifw_b),
    .if_id_flush_o(fl_b), .stall_o(st_b), .halted_o(hd_b), .stall_count_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ID instruction depends on dst: nonzero dst read as rs, or as rt when rt is used.
  function automatic bit dep(input logic [4:0] dst);
    return (dst != 0) && ((id_rs == dst) || (urt && (id_rt == dst)));
  endfunction

  function automatic bit hazard_now();
    return (ex_rd && dep(ex_reg)) || (br && ex_wr && dep(ex_reg)) ||
           (br && mem_rd && dep(mem_reg));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_drain      <= 1'b0;
      m_halted     <= 1'b0;
      m_drain_left <= 0;
      m_cnt        <= 0;
    end else if (m_halted) begin
      if (res) m_halted <= 1'b0;
    end else if (m_drain) begin
      if (m_drain_left == 1) begin
        m_drain  <= 1'b0;
        m_halted <= 1'b1;
      end
      m_drain_left <= m_drain_left - 1;
    end else if (hazard_now()) begin
      m_cnt <= m_cnt + 1;
    end else if (hlt) begin
      m_drain      <= 1'b1;
      m_drain_left <= DRN;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit frozen, hz;
      int e_pc, e_ifw, e_fl, e_st;
      frozen = m_drain || m_halted;
      hz     = !frozen && hazard_now();
      e_pc   = (!frozen && !hz && !hlt) ? 1 : 0;
      e_ifw  = (!frozen && !hz) ? 1 : 0;
      e_fl   = (!frozen && !hz && (tk || hlt)) ? 1 : 0;
      e_st   = (frozen || hz) ? 1 : 0;
      check("pc_write", int'(pc_w_a), e_pc);
      check("if_id_write", int'(ifw_a), e_ifw);
      check("if_id_flush", int'(fl_a), e_fl);
      check("stall", int'(st_a), e_st);
      check("halted", int'(hd_a), m_halted ? 1 : 0);
      check("stall_count", int'(cnt_a), (m_cnt > 65535) ? 65535 : m_cnt);
      check("stall_b", int'(st_b), e_st);
      check("halted_b", int'(hd_b), m_halted ? 1 : 0);
      check("stall_count_sat", int'(cnt_b), (m_cnt > 3) ? 3 : m_cnt);
    end
  end

  task automatic set_in(input int rs, input int rt, input bit u, input bit b,
                        input bit t, input bit h, input bit er, input bit ew,
                        input int ed, input bit mr, input int md, input bit r);
    id_rs = 5'(rs); id_rt = 5'(rt); urt = u; br = b; tk = t; hlt = h;
    ex_rd = er; ex_wr = ew; ex_reg = 5'(ed); mem_rd = mr; mem_reg = 5'(md);
    res = r;
  endtask

  task automatic cyc(input int rs, input int rt, input bit u, input bit b,
                     input bit t, input bit h, input bit er, input bit ew,
                     input int ed, input bit mr, input int md, input bit r);
    @(posedge clk); #1;
    set_in(rs, rt, u, b, t, h, er, ew, ed, mr, md, r);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_pc_write", int'(pc_w_a), 1);
    check("rst_stall", int'(st_a), 0);
    check("rst_halted", int'(hd_a), 0);
    check("rst_count", int'(cnt_a), 0);
    #10 rst = 1'b0;
    cmp_en = 1'b1;

    // EX lw $3, ID add $4,$3,$5 -> load-use stall
    cyc(3, 5, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0);
    at_neg();
    check("lu_stall", int'(st_a), 1);
    check("lu_pc_write", int'(pc_w_a), 0);
    idle();
    at_neg();
    check("lu_count", int'(cnt_a), 1);

    // EX add $7, ID beq $7,$2 -> stall; then EX writes $0 -> no stall
    cyc(7, 2, 1, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    at_neg();
    check("bex_stall", int'(st_a), 1);
    cyc(7, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    at_neg();
    check("bex_r0_stall", int'(st_a), 0);

    // MEM lw $9, ID bne $1,$9 taken -> stall, no flush; then taken -> flush
    cyc(1, 9, 1, 1, 1, 0, 0, 0, 0, 1, 9, 0);
    at_neg();
    check("bmem_flush", int'(fl_a), 0);
    cyc(1, 9, 1, 1, 1, 0, 0, 0, 0, 0, 9, 0);
    at_neg();
    check("taken_flush", int'(fl_a), 1);
    check("taken_pc_write", int'(pc_w_a), 1);

    // addi $4,$0,1 (rt unused) vs EX lw $4 -> no stall
    cyc(0, 4, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0);
    at_neg();
    check("addi_stall", int'(st_a), 0);

    // Two more load-use stalls: 5 in total, 2-bit counter sticks at 3
    cyc(6, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    cyc(6, 8, 1, 0, 0, 0, 1, 1, 6, 0, 0, 0);
    idle();
    at_neg();
    check("count_five", int'(cnt_a), 5);
    check("count_sat", int'(cnt_b), 3);

    // HALT accepted together with a taken branch: halt wins
    cyc(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("halt_flush", int'(fl_a), 1);
    check("halt_pc_write", int'(pc_w_a), 0);
    check("halt_stall", int'(st_a), 0);
    idle();                                   // drain 1
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // drain 2, resume ignored
    cyc(3, 5, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0);  // drain 3, hazard ignored
    idle();                                   // drain 4
    at_neg();
    check("drain_last_halted", int'(hd_a), 0);
    idle();
    idle();
    at_neg();
    check("halted_held", int'(hd_a), 1);
    check("halted_count", int'(cnt_a), 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // resume pulse
    idle();
    at_neg();
    check("resume_halted", int'(hd_a), 0);
    check("resume_pc_write", int'(pc_w_a), 1);

    // Reset in the second DRAIN cycle: outputs revert with no clock edge
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();                                   // drain 1
    @(posedge clk);                           // drain 2 begins
    #2 rst = 1'b1;
    #1;
    check("arst_pc_write", int'(pc_w_a), 1);
    check("arst_stall", int'(st_a), 0);
    check("arst_count", int'(cnt_a), 0);
    check("arst_halted", int'(hd_a), 0);
    #4 rst = 1'b0;
    cyc(3, 5, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0);
    idle();
    at_neg();
    check("post_rst_count", int'(cnt_a), 1);
    idle();
    at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Second-generation hazard controller for the 5-stage MIPS pipeline; sits beside decode and drives PC, IF/ID and ID/EX control.
- Generalises load-use detection to branches resolved in ID: ALU-in-EX and load-in-MEM dependencies also stall.
- Adds a halt drain state machine, taken-branch IF/ID flush, and a saturating stall-cycle counter for the debug unit.

Parameters:
- NB_REG, 5, register index width
- DRAIN_CYCLES, 4, cycles after halt acceptance before halted_o asserts (EX/MEM/WB drain)
- NB_CNT, 16, stall counter width

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- id_rs_i  in  NB_REG  rs of the instruction in ID
- id_rt_i  in  NB_REG  rt of the instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt (R-type, branch, store)
- id_is_branch_i  in  1  ID instruction is beq/bne/jr (operands needed in ID)
- id_branch_taken_i  in  1  branch/jump resolved taken in ID
- id_halt_i  in  1  ID holds HALT
- ex_mem_read_i  in  1  EX instruction is a load
- ex_reg_write_i  in  1  EX instruction writes a register
- ex_write_reg_i  in  NB_REG  EX destination
- mem_mem_read_i  in  1  MEM instruction is a load
- mem_write_reg_i  in  NB_REG  MEM destination
- resume_i  in  1  debug unit restart request
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  replace the IF/ID content with NOP
- stall_o  out  1  insert bubble into ID/EX
- halted_o  out  1  pipeline fully drained and frozen
- stall_count_o  out  NB_CNT  stall cycles since reset, saturating

Behaviour:
- Reset is asynchronous and active-high: state=RUN, drain counter=0, stall_count_o=0, halted_o=0. Combinational outputs in RUN with no hazard: pc_write_o=1, if_id_write_o=1, if_id_flush_o=0, stall_o=0.
- Register match rule: index != 0, and the rt match counts only when id_uses_rt_i=1.
- Hazard terms, evaluated in RUN only:
  - lu = ex_mem_read_i & match(ex_write_reg_i)
  - bex = id_is_branch_i & ex_reg_write_i & match(ex_write_reg_i)
  - bmem = id_is_branch_i & mem_mem_read_i & match(mem_write_reg_i)
  - haz = lu | bex | bmem
- haz=1: pc_write_o=0, if_id_write_o=0, stall_o=1, if_id_flush_o=0. id_branch_taken_i and id_halt_i are ignored that cycle because ID operands are stale.
- haz=0 and id_branch_taken_i=1: if_id_flush_o=1; PC writes normally.
- haz=0 and id_halt_i=1 (halt accepted):
  - pc_write_o=0, if_id_flush_o=1, HALT advances to EX.
  - Next state DRAIN, counter loaded with DRAIN_CYCLES-1.
  - If id_branch_taken_i is also 1, halt wins.
- DRAIN: pc_write_o=0, if_id_write_o=0, stall_o=1. Counter decrements each cycle; when counter==0, next state is HALTED. Hazard terms are ignored.
- HALTED: same freeze outputs as DRAIN, plus halted_o=1.
  - resume_i=1 -> RUN next cycle, halted_o=0 next cycle.
  - resume_i in RUN or DRAIN is ignored.
- Invalid state encoding -> RUN.
- halted_o is combinational from state; there is no latency beyond that.
- stall_count_o increments on every cycle with stall_o=1 in RUN (haz only; drain and halt cycles are not counted). It saturates at all-ones with no wrap.
- Reset mid-DRAIN or mid-HALTED returns to RUN immediately (asynchronously); the counter is cleared.

Decomposition:
- Shared package: state encoding localparams ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2, plus NOP encoding reused by the IF/ID flush logic.
- One sub-module is natural: hazard_reg_match. It is combinational; inputs are the src/dst indices and the uses flag, output is the match bit. It is instantiated for EX and MEM.

Test Plan:
- EX lw $3 with ID add $4,$3,$5 -> one cycle pc_write_o=0, if_id_write_o=0, stall_o=1; stall_count_o 0->1.
- EX add $7 with ID beq $7,$2 -> stall_o=1 for 1 cycle. Same add writing $0 -> no stall.
- MEM lw $9 with ID bne $1,$9 and taken=1 -> stall with flush=0. Next cycle, no hazard and taken -> if_id_flush_o=1, pc_write_o=1.
- ID HALT with no hazard, DRAIN_CYCLES=4 -> flush=1 in the accept cycle. DRAIN for 4 cycles, then halted_o=1 held. resume_i pulse -> RUN next cycle with pc_write_o=1.
- ID addi $4,$0,1 (id_uses_rt_i=0, rt=4) with EX lw $4 -> no stall.
- reset_i asserted in the 2nd DRAIN cycle -> outputs return to RUN values without a clock edge; stall_count_o=0. NB_CNT=2 with 5 load-use stalls -> stall_count_o saturates at 3.
